// File: rtl/hilo_mult_unit_pkg.sv
// Shared ALUOp codes and HI/LO multiplier FSM encoding, used by the decoder and hilo_mult_unit.
package hilo_mult_unit_pkg;

    localparam logic [5:0] OP_MADD  = 6'd2;
    localparam logic [5:0] OP_MSUB  = 6'd8;
    localparam logic [5:0] OP_MFHI  = 6'd15;
    localparam logic [5:0] OP_MTHI  = 6'd16;
    localparam logic [5:0] OP_MFLO  = 6'd17;
    localparam logic [5:0] OP_MTLO  = 6'd18;
    localparam logic [5:0] OP_MULT  = 6'd19;
    localparam logic [5:0] OP_MULTU = 6'd20;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIX  = 2'd2,
        ST_ACC  = 2'd3
    } state_e;

    function automatic logic is_mult_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic is_signed_op(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Any op that touches HI/LO must wait while a multiply is in flight.
    function automatic logic is_hilo_op(input logic [5:0] op);
        return is_mult_op(op) || (op == OP_MFHI) || (op == OP_MFLO) ||
               (op == OP_MTHI) || (op == OP_MTLO);
    endfunction

endpackage

// File: rtl/mult_shift_add.sv
// Radix-2 shift-add multiplier datapath: magnitude operands, 64-bit product, 5-bit step counter.
module mult_shift_add (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        step_i,
    input  logic        fix_i,
    input  logic        signed_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] prod_o,
    output logic        last_o
);

    logic [31:0] mcand_q;
    logic [63:0] prod_q;
    logic [4:0]  cnt_q;
    logic        neg_q;

    logic [31:0] abs_a, abs_b;
    logic [32:0] sum_d;

    // -0x80000000 wraps to itself, which is the correct unsigned magnitude.
    assign abs_a = (signed_i && a_i[31]) ? -a_i : a_i;
    assign abs_b = (signed_i && b_i[31]) ? -b_i : b_i;

    // Multiplier lives in the low half and is consumed as partial sums shift in.
    assign sum_d = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, mcand_q} : 33'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else if (start_i) begin
            mcand_q <= abs_a;
            prod_q  <= {32'd0, abs_b};
            cnt_q   <= '0;
            neg_q   <= signed_i & (a_i[31] ^ b_i[31]);
        end else if (step_i) begin
            prod_q  <= {sum_d, prod_q[31:1]};
            cnt_q   <= cnt_q + 5'd1;
        end else if (fix_i && neg_q) begin
            prod_q  <= -prod_q;
        end
    end

    assign prod_o = prod_q;
    assign last_o = (cnt_q == 5'd31);

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO multiply unit: IDLE/MUL/FIX/ACC sequencer, HI/LO registers and pipeline stall generation.
module hilo_mult_unit
    import hilo_mult_unit_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [5:0]  ALUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Flush,
    output logic        Stall,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut
);

    state_e      state_q;
    logic [5:0]  op_q;
    logic [31:0] hi_q, lo_q;
    logic [63:0] hilo_d;

    logic        ms_start, ms_step, ms_fix, ms_last;
    logic [63:0] prod;

    assign ms_start = (state_q == ST_IDLE) && Start && !Flush && is_mult_op(ALUOp);
    assign ms_step  = (state_q == ST_MUL) && !Flush;
    assign ms_fix   = (state_q == ST_FIX) && !Flush;

    mult_shift_add u_msa (
        .clk_i    (Clk),
        .rst_i    (Reset),
        .start_i  (ms_start),
        .step_i   (ms_step),
        .fix_i    (ms_fix),
        .signed_i (is_signed_op(ALUOp)),
        .a_i      (A),
        .b_i      (B),
        .prod_o   (prod),
        .last_o   (ms_last)
    );

    always_comb begin
        hilo_d = prod;
        case (op_q)
            OP_MADD: hilo_d = {hi_q, lo_q} + prod;
            OP_MSUB: hilo_d = {hi_q, lo_q} - prod;
            default: hilo_d = prod;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start && !Flush) begin
                        if (is_mult_op(ALUOp)) begin
                            op_q    <= ALUOp;
                            state_q <= ST_MUL;
                        end else if (ALUOp == OP_MTHI) begin
                            hi_q <= A;
                        end else if (ALUOp == OP_MTLO) begin
                            lo_q <= A;
                        end
                    end
                end
                ST_MUL: begin
                    if (Flush)        state_q <= ST_IDLE;
                    else if (ms_last) state_q <= ST_FIX;
                end
                ST_FIX: state_q <= Flush ? ST_IDLE : ST_ACC;
                ST_ACC: begin
                    if (!Flush) {hi_q, lo_q} <= hilo_d;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Done is gated by Flush in the same cycle so a flushed ACC never reports a commit.
    assign Busy  = (state_q != ST_IDLE);
    assign Done  = (state_q == ST_ACC) && !Flush;
    assign Stall = Start && Busy && is_hilo_op(ALUOp) && !Reset;
    assign HiOut = hi_q;
    assign LoOut = lo_q;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed-vector bench for hilo_mult_unit: latency, signed/unsigned products, accumulate, stall, flush, reset.
module tb_hilo_mult_unit;
    import hilo_mult_unit_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset, Start, Flush;
    logic [5:0]  ALUOp;
    logic [31:0] A, B;
    logic        Stall, Busy, Done;
    logic [31:0] HiOut, LoOut;

    int errs = 0;
    int nchk = 0;

    hilo_mult_unit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .ALUOp (ALUOp),
        .A     (A),
        .B     (B),
        .Flush (Flush),
        .Stall (Stall),
        .Busy  (Busy),
        .Done  (Done),
        .HiOut (HiOut),
        .LoOut (LoOut)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1; ALUOp = op; A = a; B = b;
        tick();
        Start = 1'b0; ALUOp = 6'd0;
    endtask

    task automatic mt(input logic [5:0] op, input logic [31:0] val);
        issue(op, val, 32'd0);
    endtask

    // Issue at cycle N, expect Done only at N+34 and the result at N+35.
    task automatic run_mul(input string tag, input logic [5:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int bad = 0;
        Start = 1'b1; ALUOp = op; A = a; B = b;
        #1;
        chk({tag, "_stall_idle"}, 64'(Stall), 64'd0);
        tick();
        Start = 1'b0; ALUOp = 6'd0;
        chk({tag, "_busy"}, 64'(Busy), 64'd1);
        for (int c = 1; c < 35; c++) begin
            if (c == 34) chk({tag, "_done_n34"}, 64'(Done), 64'd1);
            else if (Done !== 1'b0) bad++;
            tick();
        end
        chk({tag, "_done_extra"}, 64'(bad), 64'd0);
        chk({tag, "_hi"}, 64'(HiOut), 64'(eh));
        chk({tag, "_lo"}, 64'(LoOut), 64'(el));
        chk({tag, "_idle"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        Reset = 1'b1; Start = 1'b1; ALUOp = OP_MULT; Flush = 1'b0; A = '0; B = '0;
        tick(); tick();
        chk("rst_stall", 64'(Stall), 64'd0);
        chk("rst_hi",    64'(HiOut), 64'd0);
        chk("rst_lo",    64'(LoOut), 64'd0);
        chk("rst_busy",  64'(Busy),  64'd0);
        chk("rst_done",  64'(Done),  64'd0);
        Start = 1'b0; ALUOp = 6'd0;
        Reset = 1'b0;
        tick();

        run_mul("multu_ff", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_mul("mult_m2x3", OP_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        run_mul("multu_m2x3", OP_MULTU, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA);
        run_mul("mult_min", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
        run_mul("mult_7xm6", OP_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);

        mt(OP_MTHI, 32'h12345678);
        chk("mthi_val",  64'(HiOut), 64'h12345678);
        chk("mthi_busy", 64'(Busy),  64'd0);
        mt(OP_MTHI, 32'd0);
        mt(OP_MTLO, 32'd10);
        chk("mtlo_val",  64'(LoOut), 64'd10);
        run_mul("madd", OP_MADD, 32'd4, 32'd5, 32'd0, 32'd30);
        run_mul("msub", OP_MSUB, 32'hFFFFFFFF, 32'd31, 32'd0, 32'd61);

        // Unlisted opcode in IDLE does nothing.
        Start = 1'b1; ALUOp = 6'd5; A = 32'hDEAD;
        #1;
        chk("unk_stall", 64'(Stall), 64'd0);
        tick();
        Start = 1'b0;
        chk("unk_busy", 64'(Busy), 64'd0);
        chk("unk_lo",   64'(LoOut), 64'd61);

        // Flush together with Start in IDLE is not accepted.
        Start = 1'b1; ALUOp = OP_MULT; A = 32'd2; B = 32'd2; Flush = 1'b1;
        tick();
        Start = 1'b0; Flush = 1'b0;
        chk("flush_start_busy", 64'(Busy), 64'd0);

        // mflo issued at N+5 stalls through N+34 and reads the new LO at N+35.
        issue(OP_MULT, 32'd7, 32'd6);
        repeat (4) tick();
        Start = 1'b1; ALUOp = OP_MFLO;
        #1;
        bad = 0;
        for (int c = 5; c < 35; c++) begin
            if (Stall !== 1'b1) bad++;
            tick();
        end
        chk("mflo_stall_held", 64'(bad), 64'd0);
        chk("mflo_stall_rel",  64'(Stall), 64'd0);
        chk("mflo_lo",         64'(LoOut), 64'd42);
        Start = 1'b0; ALUOp = 6'd0;

        // Flush at N+20 of a madd.
        mt(OP_MTHI, 32'd1);
        mt(OP_MTLO, 32'd2);
        issue(OP_MADD, 32'd3, 32'd4);
        Start = 1'b1; ALUOp = 6'd5;
        #1;
        chk("busy_unk_stall", 64'(Stall), 64'd0);
        Start = 1'b0; ALUOp = 6'd0;
        repeat (19) tick();
        Flush = 1'b1;
        #1;
        chk("flush_mul_done", 64'(Done), 64'd0);
        tick();
        Flush = 1'b0;
        chk("flush_mul_busy", 64'(Busy),  64'd0);
        chk("flush_mul_hi",   64'(HiOut), 64'd1);
        chk("flush_mul_lo",   64'(LoOut), 64'd2);
        bad = 0;
        repeat (20) begin
            if (Done !== 1'b0) bad++;
            tick();
        end
        chk("flush_mul_nodone", 64'(bad), 64'd0);

        // Flush during ACC suppresses the commit.
        issue(OP_MADD, 32'd3, 32'd4);
        repeat (33) tick();
        chk("acc_busy", 64'(Busy), 64'd1);
        Flush = 1'b1;
        #1;
        chk("flush_acc_done", 64'(Done), 64'd0);
        tick();
        Flush = 1'b0;
        chk("flush_acc_hi",   64'(HiOut), 64'd1);
        chk("flush_acc_lo",   64'(LoOut), 64'd2);
        chk("flush_acc_busy", 64'(Busy),  64'd0);

        // Reset at N+33 clears HI/LO immediately and never commits.
        mt(OP_MTHI, 32'd5);
        mt(OP_MTLO, 32'd6);
        issue(OP_MULT, 32'd3, 32'd3);
        repeat (32) tick();
        Reset = 1'b1;
        #1;
        chk("rst_mid_hi",   64'(HiOut), 64'd0);
        chk("rst_mid_lo",   64'(LoOut), 64'd0);
        chk("rst_mid_busy", 64'(Busy),  64'd0);
        chk("rst_mid_done", 64'(Done),  64'd0);
        tick(); tick();
        Reset = 1'b0;
        bad = 0;
        repeat (5) begin
            if (Done !== 1'b0) bad++;
            tick();
        end
        chk("rst_mid_nodone", 64'(bad), 64'd0);
        chk("rst_mid_lo_after", 64'(LoOut), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule

// File: doc/hilo_mult_unit.md
HILO_MULT_UNIT -- requirements
Module: hilo_mult_unit

Interface
REQ-001 The module SHALL have exactly one clock and an asynchronous, active-high reset: Clk input 1, rising-edge clock; Reset input 1, asynchronous active-high reset.
REQ-002 The module SHALL provide port Start, input, width 1: EX-stage instruction valid.
REQ-003 The module SHALL provide port ALUOp, input, width 6: decoder opcode; the codes are 2 madd, 8 msub, 15 mfhi, 16 mthi, 17 mflo, 18 mtlo, 19 mult, 20 multu; all other codes are ignored.
REQ-004 The module SHALL provide port A, input, width 32: rs operand.
REQ-005 The module SHALL provide port B, input, width 32: rt operand.
REQ-006 The module SHALL provide port Flush, input, width 1: pipeline flush that aborts an in-flight operation.
REQ-007 The module SHALL provide port Stall, output, width 1: freeze IF/ID/EX this cycle.
REQ-008 The module SHALL provide port Busy, output, width 1: high when the FSM is not IDLE.
REQ-009 The module SHALL provide port Done, output, width 1: one-cycle pulse in the cycle HI/LO commit.
REQ-010 The module SHALL provide port HiOut, output, width 32: HI register value.
REQ-011 The module SHALL provide port LoOut, output, width 32: LO register value.

Function
REQ-012 Mult-class ops SHALL be {mult, multu, madd, msub}; madd and msub SHALL be signed.
REQ-013 The FSM SHALL have four states: IDLE, MUL, FIX, ACC.
REQ-014 In IDLE, when Start=1 with a mult-class op, the unit SHALL latch A, B and the op and go to MUL with the counter at 0, without asserting Stall.
REQ-015 MUL SHALL perform radix-2 unsigned shift-add, one bit per cycle, for exactly 32 cycles, then go to FIX.
REQ-016 For signed ops, MUL SHALL operate on absolute values; the absolute value of 0x80000000 SHALL be 0x80000000 treated as unsigned.
REQ-017 FIX SHALL last 1 cycle; it SHALL negate the 64-bit product (two's complement) when the op is signed and A[31]^B[31]=1.
REQ-018 ACC SHALL last 1 cycle and SHALL set HI:LO to P (mult/multu), HI:LO+P (madd), or HI:LO-P (msub); arithmetic SHALL be modulo 2^64; Done=1; next state IDLE.
REQ-019 Latency SHALL be: accepted in cycle N, MUL occupies N+1..N+32, FIX N+33, ACC N+34, and the new HI/LO is visible in cycle N+35.
REQ-020 Busy SHALL be 1 in MUL, FIX and ACC.
REQ-021 Stall SHALL be combinational and SHALL equal Start AND Busy AND (the op is mult-class or mfhi/mflo/mthi/mtlo); a stalled op SHALL NOT be accepted.
REQ-022 A stalled op SHALL be accepted in the first cycle after Busy falls.
REQ-023 HiOut and LoOut SHALL show the registers directly; mfhi and mflo SHALL read them combinationally in the unstalled cycle.
REQ-024 With mthi or mtlo and Start=1 in IDLE, HI or LO SHALL take A at the next edge; the FSM SHALL stay in IDLE and Done SHALL stay 0.
REQ-025 Flush=1 in any state other than IDLE SHALL return the FSM to IDLE at the next edge, leave HI/LO unchanged, and keep Done=0; Flush in ACC SHALL suppress the commit.
REQ-026 Flush=1 and Start=1 together in IDLE SHALL NOT be accepted.
REQ-027 Ops not listed in REQ-003 SHALL cause no state change and Stall=0.

Reset
REQ-028 Reset SHALL asynchronously force: FSM to IDLE, counter to 0, HI=0, LO=0, Done=0, Busy=0, and the product/operand registers to 0.
REQ-029 Stall SHALL be 0 while Reset=1.
REQ-030 Reset mid-operation SHALL discard the operation and SHALL NOT commit.

Structure
REQ-031 A shared package SHALL hold the ALUOp code constants (2, 8, 15-20) and the FSM state encoding, for use by both the decoder and this unit.
REQ-032 The shift-add datapath (operand registers, 64-bit product, 5-bit counter) SHALL be one sub-module, mult_shift_add, with start/step inputs; the FSM, HI/LO and stall logic SHALL stay in the top module.

Verification
REQ-033 multu with A=0xFFFFFFFF, B=0xFFFFFFFF SHALL give, at N+35, HI=0xFFFFFFFE and LO=0x00000001, with Done high only in N+34.
REQ-034 mult with A=0xFFFFFFFE (-2), B=3 SHALL give HI=0xFFFFFFFF and LO=0xFFFFFFFA; mult with A=B=0x80000000 SHALL give HI=0x40000000 and LO=0.
REQ-035 mthi 0, mtlo 10, then madd with A=4, B=5 SHALL give LO=30; a following msub with A=-1, B=31 SHALL give LO=61 and HI=0.
REQ-036 mflo issued at N+5 after a mult accepted at N SHALL hold Stall=1 through N+34, and the mflo in N+35 SHALL read the new LO.
REQ-037 Flush at N+20 of a madd with HI:LO=0x1:0x2 SHALL return the FSM to IDLE at N+21 with Busy=0, HI:LO still 0x1:0x2, and no Done pulse.
REQ-038 Reset asserted at N+33 SHALL clear HI/LO to 0 immediately, with no Done pulse.
